// File: rtl/pearson_hash_stream.sv
// pearson_hash_stream: streaming multi-lane Pearson hash over a valid/ready byte stream.
// Ports:
//   clock, reset_n       rising-edge clock, synchronous active-low reset
//   perm_table           256-entry permutation table, entry i at [8i+7:8i]
//   in_data/in_valid/in_last/in_ready  message byte stream, in_last marks final byte
//   hash/msg_len/out_valid/out_ready   digest (lane k at [8k+7:8k]) and saturating byte count
module pearson_hash_stream #(
  parameter int NUM_LANES = 4,
  parameter int LEN_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2047:0]          perm_table,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [8*NUM_LANES-1:0] hash,
  output logic [LEN_W-1:0]       msg_len,
  output logic                   out_valid,
  input  logic                   out_ready
);
  typedef enum logic [1:0] {FIRST, ACCUM, DONE} state_t;
  state_t state;
  logic [8*NUM_LANES-1:0] h, h_next;
  logic [LEN_W-1:0] cnt, cnt_next;
  logic [7:0] idx [NUM_LANES];
  logic accept;
  assign accept = in_valid && in_ready;
  // The first byte seeds each lane with a lane-offset index so lanes diverge;
  // later bytes chain through the previous lane value.
  always_comb begin
    h_next = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx[k] = state == FIRST ? in_data + 8'(k) : h[8*k +: 8] ^ in_data;
      h_next[8*k +: 8] = perm_table[{idx[k], 3'b000} +: 8];
    end
    cnt_next = state == FIRST ? LEN_W'(1) : (&cnt ? cnt : cnt + 1'b1);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= FIRST;
      h <= '0;
      cnt <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      hash <= '0;
      msg_len <= '0;
    end else begin
      case (state)
        FIRST, ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            h <= h_next;
            cnt <= cnt_next;
            state <= in_last ? DONE : ACCUM;
            if (in_last) begin
              in_ready <= 1'b0;
              out_valid <= 1'b1;
              hash <= h_next;
              msg_len <= cnt_next;
            end
          end
        end
        DONE: if (out_ready) begin
          state <= FIRST;
          in_ready <= 1'b1;
          out_valid <= 1'b0;
          hash <= '0;
          msg_len <= '0;
        end
        default: state <= FIRST;
      endcase
    end
  end
endmodule

// File: tb/tb_pearson_hash_stream.sv
// tb_pearson_hash_stream: scoreboard bench for pearson_hash_stream against a byte-array reference model.
module tb_pearson_hash_stream;
  localparam int L = 2;
  localparam int W = 4;
  logic clock = 0, reset_n = 0;
  logic [2047:0] perm_table = '0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_last = 0, in_ready, out_valid, out_ready = 0;
  logic [8*L-1:0] hash;
  logic [W-1:0] msg_len;
  typedef struct packed {logic [8*L-1:0] h; logic [W-1:0] n;} exp_t;
  exp_t q[$];
  logic [7:0] tt [256];
  logic [7:0] msg[$];
  int errors = 0, checks = 0;
  bit rand_ready = 0;

  pearson_hash_stream #(.NUM_LANES(L), .LEN_W(W)) dut (
    .clock(clock), .reset_n(reset_n), .perm_table(perm_table),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .hash(hash), .msg_len(msg_len), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] m[$]);
    exp_t e;
    logic [7:0] v;
    for (int k = 0; k < L; k++) begin
      v = tt[8'(m[0] + 8'(k))];
      for (int i = 1; i < m.size(); i++) v = tt[v ^ m[i]];
      e.h[8*k +: 8] = v;
    end
    e.n = (m.size() > (1 << W) - 1) ? '1 : W'(m.size());
    return e;
  endfunction

  task automatic set_table(input int mode);
    logic [7:0] t;
    for (int i = 0; i < 256; i++) tt[i] = mode == 1 ? ~8'(i) : 8'(i);
    if (mode == 2)
      for (int i = 255; i > 0; i--) begin
        int j = $urandom_range(0, i);
        t = tt[i]; tt[i] = tt[j]; tt[j] = t;
      end
    for (int i = 0; i < 256; i++) perm_table[8*i +: 8] = tt[i];
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input bit last, input bit gaps);
    int n = 0;
    if (gaps) begin
      in_valid = 0;
      repeat ($urandom_range(1, 3)) cycle();
    end
    in_data = d;
    in_valid = 1;
    in_last = last;
    while (!in_ready && n < 100) begin cycle(); n++; end
    if (n >= 100) begin
      errors++; checks++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 100 cycles");
    end
    cycle();
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic send(input bit gaps);
    q.push_back(model(msg));
    for (int i = 0; i < msg.size(); i++) put(msg[i], i == msg.size() - 1, gaps);
  endtask

  task automatic take();
    out_ready = 1;
    cycle();
    out_ready = 0;
  endtask

  task automatic rand_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  always @(negedge clock) if (reset_n) begin
    if (out_valid) begin
      chk("in_ready_in_done", in_ready, 0);
      if (q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_output: got hash=%0h len=%0d expected no output", hash, msg_len);
      end else begin
        chk("hash", hash, q[0].h);
        chk("msg_len", msg_len, q[0].n);
        if (out_ready) void'(q.pop_front());
      end
    end else begin
      chk("idle_hash", hash, 0);
      chk("idle_len", msg_len, 0);
    end
  end

  always @(posedge clock) if (rand_ready) begin
    #1;
    out_ready = $urandom_range(0, 2) != 0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [8*L-1:0] h0;
    int n;
    set_table(0);
    repeat (2) cycle();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hash", hash, 0);
    chk("rst_len", msg_len, 0);
    reset_n = 1;
    cycle();
    chk("post_rst_in_ready", in_ready, 1);
    msg.delete(); msg.push_back(8'h12); msg.push_back(8'h34);
    send(0);
    chk("latency_valid", out_valid, 1);
    chk("ident_hash", hash, 16'h2726);
    chk("ident_len", msg_len, 2);
    h0 = hash;
    repeat (5) begin
      cycle();
      chk("bp_hash_stable", hash, h0);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    take();
    chk("turn_valid", out_valid, 0);
    chk("turn_in_ready", in_ready, 1);
    set_table(1);
    msg.delete(); msg.push_back(8'h00);
    send(0);
    chk("compl_hash", hash, 16'hFEFF);
    chk("compl_len", msg_len, 1);
    take();
    msg.delete(); msg.push_back(8'h12); msg.push_back(8'h34);
    send(0);
    chk("compl_lane0", hash[7:0], 8'h26);
    take();
    set_table(0);
    msg.delete(); msg.push_back(8'hFF);
    send(0);
    chk("wrap_hash", hash, 16'h00FF);
    take();
    set_table(2);
    rand_msg(6);
    send(0);
    take();
    send(1);
    take();
    rand_msg(20);
    send(1);
    chk("sat_len", msg_len, 15);
    take();
    rand_msg(5);
    for (int i = 0; i < 3; i++) put(msg[i], 0, 0);
    reset_n = 0;
    cycle();
    chk("abort_in_ready", in_ready, 0);
    chk("abort_valid", out_valid, 0);
    reset_n = 1;
    cycle();
    rand_msg(2);
    send(0);
    take();
    rand_ready = 1;
    for (int m = 0; m < 30; m++) begin
      rand_msg($urandom_range(1, 20));
      send($urandom_range(0, 1) == 1);
    end
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin cycle(); n++; end
    if (n >= 500) begin
      errors++; checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    rand_ready = 0;
    repeat (2) cycle();
    chk("final_queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
